// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer
// Drives an external 16-bit ripple-carry adder one word per cycle to add or
// subtract NWORDS*16-bit operands, chaining the carry between words. Operands
// arrive on a valid/ready handshake; the result, carry-out and signed overflow
// leave on a second valid/ready handshake.
module multiword_add_sequencer #(
  parameter  int unsigned NWORDS = 4,
  localparam int unsigned W      = 16 * NWORDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  input  logic         in_sub,
  output logic [15:0]  add_a,
  output logic [15:0]  add_b,
  output logic         add_cin,
  input  logic [15:0]  add_sum,
  input  logic         add_cout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout,
  output logic         out_ovf
);

  localparam int unsigned     IW       = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IW-1:0]   LAST_IDX = IW'(NWORDS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          carry_q, carry_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;
  logic          valid_q, valid_d;

  // Bit offset of the word currently being processed.
  logic [IW+3:0] word_sh;
  logic          run;

  // Adder feed: current operand words and chained carry while running, 0 otherwise.
  always_comb begin
    word_sh = {idx_q, 4'b0000};
    run     = (state_q == S_RUN);
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (run) begin
      add_a   = a_q[word_sh +: 16];
      add_b   = b_q[word_sh +: 16];
      add_cin = carry_q;
    end
  end

  // Next-state logic for the sequencer and its result registers.
  // DONE spends its first cycle latching cout/ovf from the completed sum,
  // so out_valid rises one edge after the last word is stored.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_sub ? ~in_b : in_b;
          carry_d = in_cin ^ in_sub;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[word_sh +: 16] = add_sum;
        carry_d              = add_cout;
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        if (!valid_q) begin
          valid_d = 1'b1;
          cout_d  = carry_q;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (sum_q[W-1] != a_q[W-1]);
        end else if (out_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; async reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  // Handshake and result outputs.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = valid_q;
    out_sum   = sum_q;
    out_cout  = cout_q;
    out_ovf   = ovf_q;
  end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Scoreboard bench for multiword_add_sequencer at NWORDS=4 and NWORDS=1.
// Expected results come from a wide-integer arithmetic model; a monitor per
// instance pops and compares whenever a result handshake occurs.
module tb_multiword_add_sequencer;

  localparam int NW4 = 4;
  localparam int NW1 = 1;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    int          issue;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;

  exp_t q4[$];
  exp_t q1[$];
  int   rdy_mode4;
  int   rdy_mode1;

  // NWORDS=4 instance signals
  logic        in_valid4, in_ready4, cin4, sub4;
  logic [63:0] a4, b4;
  logic [15:0] add_a4, add_b4, add_sum4;
  logic        add_cin4, add_cout4;
  logic        out_valid4, out_ready4, out_cout4, out_ovf4;
  logic [63:0] out_sum4;

  // NWORDS=1 instance signals
  logic        in_valid1, in_ready1, cin1, sub1;
  logic [15:0] a1, b1;
  logic [15:0] add_a1, add_b1, add_sum1;
  logic        add_cin1, add_cout1;
  logic        out_valid1, out_ready1, out_cout1, out_ovf1;
  logic [15:0] out_sum1;

  multiword_add_sequencer #(.NWORDS(NW4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .in_a(a4), .in_b(b4), .in_cin(cin4), .in_sub(sub4),
    .add_a(add_a4), .add_b(add_b4), .add_cin(add_cin4),
    .add_sum(add_sum4), .add_cout(add_cout4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .out_sum(out_sum4), .out_cout(out_cout4), .out_ovf(out_ovf4)
  );

  multiword_add_sequencer #(.NWORDS(NW1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(a1), .in_b(b1), .in_cin(cin1), .in_sub(sub1),
    .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
    .add_sum(add_sum1), .add_cout(add_cout1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_sum(out_sum1), .out_cout(out_cout1), .out_ovf(out_ovf1)
  );

  // External 16-bit adders the sequencers drive.
  assign {add_cout4, add_sum4} = 17'(add_a4) + 17'(add_b4) + 17'(add_cin4);
  assign {add_cout1, add_sum1} = 17'(add_a1) + 17'(add_b1) + 17'(add_cin1);

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    fails++;
    $display("FAIL %s: timed out at cycle %0d", nm, cyc);
  endtask

  // Reference: w-bit add/sub as plain integer arithmetic.
  // add: A + B + cin ; sub: A - B - cin (cout = no borrow).
  function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b,
                                input logic cin, input logic sub,
                                output logic [63:0] sum, output logic cout, output logic ovf);
    logic [65:0]        ua, ub, r, mask;
    logic signed [65:0] sa, sb, sc, sr, lim;
    mask = (66'd1 << w) - 66'd1;
    ua   = {2'b00, a} & mask;
    ub   = {2'b00, b} & mask;
    if (sub) r = (66'd1 << w) + ua - ub - {65'd0, cin};
    else     r = ua + ub + {65'd0, cin};
    sum  = 64'(r & mask);
    cout = r[w];
    sa   = ua << (66 - w);
    sa   = sa >>> (66 - w);
    sb   = ub << (66 - w);
    sb   = sb >>> (66 - w);
    sc   = {65'd0, cin};
    sr   = sub ? (sa - sb - sc) : (sa + sb + sc);
    lim  = 66'sd1 <<< (w - 1);
    ovf  = (sr >= lim) || (sr < -lim);
  endfunction

  function automatic logic [63:0] rand64();
    case ($urandom_range(0, 6))
      0:       return 64'h0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      4:       return 64'h0000_0000_0000_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Consumer ready generation, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (rdy_mode4)
      0:       out_ready4 = ($urandom_range(0, 3) != 0);
      1:       out_ready4 = 1'b0;
      default: out_ready4 = 1'b1;
    endcase
    case (rdy_mode1)
      0:       out_ready1 = ($urandom_range(0, 2) != 0);
      1:       out_ready1 = 1'b0;
      default: out_ready1 = 1'b1;
    endcase
  end

  // Call at a falling edge.
  task automatic issue4(input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sub);
    exp_t e;
    int   n;
    n = 0;
    while (in_ready4 !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (in_ready4 !== 1'b1) begin
      timeout_fail("issue4_ready");
      return;
    end
    a4 = a; b4 = b; cin4 = cin; sub4 = sub; in_valid4 = 1'b1;
    model(64, a, b, cin, sub, e.sum, e.cout, e.ovf);
    e.issue = cyc + 1;
    q4.push_back(e);
    @(negedge clk);
    in_valid4 = 1'b0;
    a4 = {$urandom, $urandom}; b4 = {$urandom, $urandom};
    cin4 = 1'($urandom); sub4 = 1'($urandom);
  endtask

  task automatic issue1(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
    exp_t e;
    int   n;
    n = 0;
    while (in_ready1 !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (in_ready1 !== 1'b1) begin
      timeout_fail("issue1_ready");
      return;
    end
    a1 = a; b1 = b; cin1 = cin; sub1 = sub; in_valid1 = 1'b1;
    model(16, {48'h0, a}, {48'h0, b}, cin, sub, e.sum, e.cout, e.ovf);
    e.issue = cyc + 1;
    q1.push_back(e);
    @(negedge clk);
    in_valid1 = 1'b0;
    a1 = 16'($urandom); b1 = 16'($urandom);
    cin1 = 1'($urandom); sub1 = 1'($urandom);
  endtask

  task automatic drain4();
    int n;
    n = 0;
    while (q4.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (q4.size() != 0) timeout_fail("drain4");
  endtask

  task automatic drain1();
    int n;
    n = 0;
    while (q1.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (q1.size() != 0) timeout_fail("drain1");
  endtask

  // Monitor for the NWORDS=4 instance.
  logic prev4 = 1'b0;
  always @(negedge clk) begin : mon4
    exp_t e;
    if (!rst_n) begin
      prev4 = 1'b0;
    end else begin
      if (out_valid4 === 1'b1) begin
        if (q4.size() == 0) begin
          chk("unexpected_valid4", 64'(out_valid4), 64'h0);
        end else begin
          if (!prev4) chk("latency4", 64'(cyc - q4[0].issue), 64'(NW4 + 1));
          chk("in_ready_busy4", 64'(in_ready4), 64'h0);
          if (out_ready4 === 1'b1) begin
            e = q4.pop_front();
            chk("sum4", out_sum4, e.sum);
            chk("cout4", 64'(out_cout4), 64'(e.cout));
            chk("ovf4", 64'(out_ovf4), 64'(e.ovf));
          end
        end
      end
      prev4 = out_valid4;
    end
  end

  // Monitor for the NWORDS=1 instance.
  logic prev1 = 1'b0;
  always @(negedge clk) begin : mon1
    exp_t e;
    if (!rst_n) begin
      prev1 = 1'b0;
    end else begin
      if (out_valid1 === 1'b1) begin
        if (q1.size() == 0) begin
          chk("unexpected_valid1", 64'(out_valid1), 64'h0);
        end else begin
          if (!prev1) chk("latency1", 64'(cyc - q1[0].issue), 64'(NW1 + 1));
          if (out_ready1 === 1'b1) begin
            e = q1.pop_front();
            chk("sum1", 64'(out_sum1), e.sum);
            chk("cout1", 64'(out_cout1), 64'(e.cout));
            chk("ovf1", 64'(out_ovf1), 64'(e.ovf));
          end
        end
      end
      prev1 = out_valid1;
    end
  end

  initial begin : main
    logic [63:0] ra, rb, bp_sum, rst_a;
    logic        bp_cout, bp_ovf;
    int          n;

    rst_n = 1'b0;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0;
    rdy_mode4 = 2;
    rdy_mode1 = 2;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_out_valid4", 64'(out_valid4), 64'h0);
    chk("rst_out_sum4", out_sum4, 64'h0);
    chk("rst_out_cout4", 64'(out_cout4), 64'h0);
    chk("rst_out_ovf4", 64'(out_ovf4), 64'h0);
    chk("rst_add4", {31'h0, add_cin4, add_a4, add_b4}, 64'h0);
    chk("rst_out_valid1", 64'(out_valid1), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready4", 64'(in_ready4), 64'h1);
    chk("rst_in_ready1", 64'(in_ready1), 64'h1);

    // Carry ripple through every word, sub with borrow across words, overflow cases
    issue4(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    issue4(64'h0000_0001_0000_0000, 64'h1, 1'b0, 1'b0 ^ 1'b1);
    issue4(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    issue4(64'h0, 64'h1, 1'b0, 1'b1);
    issue4(64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1);
    issue4(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b1);
    drain4();

    // Backpressure: result held for 10 cycles, then released
    rdy_mode4 = 1;
    @(negedge clk);
    issue4(64'hDEAD_BEEF_0000_FFFF, 64'h2152_4111_0000_0001, 1'b1, 1'b0);
    model(64, 64'hDEAD_BEEF_0000_FFFF, 64'h2152_4111_0000_0001, 1'b1, 1'b0, bp_sum, bp_cout, bp_ovf);
    n = 0;
    while (out_valid4 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (out_valid4 !== 1'b1) timeout_fail("bp_wait_valid");
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", 64'(out_valid4), 64'h1);
      chk("bp_in_ready", 64'(in_ready4), 64'h0);
      chk("bp_sum", out_sum4, bp_sum);
      chk("bp_cout", 64'(out_cout4), 64'(bp_cout));
      @(negedge clk);
    end
    rdy_mode4 = 2;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", 64'(in_ready4), 64'h1);
    chk("bp_release_out_valid", 64'(out_valid4), 64'h0);

    // Reset in the middle of RUN at word index 2
    rst_a = 64'hAAAA_5555_3333_CCCC;
    issue4(rst_a, 64'h1111_2222_4444_8888, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("mid_run_word2", 64'(add_a4), 64'(rst_a[47:32]));
    rst_n = 1'b0;
    #1;
    q4.delete();
    chk("abort_out_valid", 64'(out_valid4), 64'h0);
    chk("abort_add", {31'h0, add_cin4, add_a4, add_b4}, 64'h0);
    chk("abort_out_sum", out_sum4, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", 64'(in_ready4), 64'h1);
    chk("abort_out_valid_after", 64'(out_valid4), 64'h0);
    issue4(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0);
    drain4();

    // Randomised traffic with random consumer backpressure
    rdy_mode4 = 0;
    for (int i = 0; i < 40; i++) begin
      ra = rand64();
      rb = rand64();
      issue4(ra, rb, 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    drain4();

    // Single-word instance
    issue1(16'hFFFF, 16'h0001, 1'b1, 1'b0);
    issue1(16'h0000, 16'h0001, 1'b0, 1'b1);
    issue1(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    issue1(16'h8000, 16'h0001, 1'b1, 1'b1);
    drain1();
    rdy_mode1 = 0;
    for (int i = 0; i < 25; i++) begin
      ra = rand64();
      rb = rand64();
      issue1(ra[15:0], rb[31:16], 1'($urandom), 1'($urandom));
    end
    drain1();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
